// File: rtl/stream_demux1_2_pkg.sv
// Shared definitions for the 1:2 stream demux: FSM state encoding and destination select helper.
package stream_demux1_2_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  // Destination is free-running on in_sel only between packets; a locked packet pins it.
  function automatic logic dest_of(input state_t st, input logic sel);
    case (st)
      ST_LOCK0: dest_of = 1'b0;
      ST_LOCK1: dest_of = 1'b1;
      default:  dest_of = sel;
    endcase
  endfunction

endpackage

// File: rtl/stream_demux1_2_reg.sv
// One-entry valid/ready register slice carrying data plus a last flag.
module stream_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop_ready,
  input  logic [DATA_W-1:0] d,
  input  logic              d_last,
  output logic              can_take,
  output logic              q_valid,
  output logic [DATA_W-1:0] q,
  output logic              q_last
);

  // Room exists if empty or the held beat leaves this cycle, so push+pop never bubbles.
  assign can_take = !q_valid | pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q       <= '0;
      q_last  <= 1'b0;
    end else if (push) begin
      q_valid <= 1'b1;
      q       <= d;
      q_last  <= d_last;
    end else if (pop_ready) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux1_2.sv
// 1-to-2 packet demux: destination picked by in_sel on a packet's first beat and held until in_last.
module stream_demux1_2
  import stream_demux1_2_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [STATE_W-1:0] dbg_state
);

  // Handshake: a beat transfers on a cycle where valid & ready are both high; valid never
  // waits on ready, and a held output beat keeps data/last/valid stable until it transfers.
  state_t state;
  logic   dest;
  logic   can_take0;
  logic   can_take1;
  logic   accept;
  logic   push0;
  logic   push1;

  assign dest      = dest_of(state, in_sel);
  assign in_ready  = rst_n & (dest ? can_take1 : can_take0);
  assign accept    = in_valid & in_ready;
  assign push0     = accept & ~dest;
  assign push1     = accept & dest;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !in_last) state <= in_sel ? ST_LOCK1 : ST_LOCK0;
        end
        ST_LOCK0, ST_LOCK1: begin
          if (accept && in_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  stream_reg #(.DATA_W(DATA_W)) u_out0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .pop_ready (out0_ready),
    .d         (in_data),
    .d_last    (in_last),
    .can_take  (can_take0),
    .q_valid   (out0_valid),
    .q         (out0_data),
    .q_last    (out0_last)
  );

  stream_reg #(.DATA_W(DATA_W)) u_out1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .pop_ready (out1_ready),
    .d         (in_data),
    .d_last    (in_last),
    .can_take  (can_take1),
    .q_valid   (out1_valid),
    .q         (out1_data),
    .q_last    (out1_last)
  );

  // Delivered-beat counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready) cnt0 <= cnt0 + CNT_W'(1);
      if (out1_valid && out1_ready) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux1_2.sv
// Bench for stream_demux1_2: vector table, directed corner sequences and a random run against a queue model.
module tb_stream_demux1_2;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_sel;
  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out0_data;
  logic              out0_last;
  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out1_data;
  logic              out1_last;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;
  logic [1:0]        dbg_state;

  stream_demux1_2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: expected queue per output ({last, data}), last loaded value, counters, packet lock
  logic [DATA_W:0] exp_q0[$];
  logic [DATA_W:0] exp_q1[$];
  logic [DATA_W:0] hold0;
  logic [DATA_W:0] hold1;
  int              m_cnt0;
  int              m_cnt1;
  bit              m_in_pkt;
  bit              m_dest;
  int              errors = 0;
  int              checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    hold0    = '0;
    hold1    = '0;
    m_cnt0   = 0;
    m_cnt1   = 0;
    m_in_pkt = 1'b0;
    m_dest   = 1'b0;
  endtask

  function automatic logic model_dest();
    return m_in_pkt ? m_dest : in_sel;
  endfunction

  function automatic logic model_ready();
    logic room;
    room = model_dest() ? (exp_q1.size() == 0 || out1_ready) : (exp_q0.size() == 0 || out0_ready);
    return rst_n && room;
  endfunction

  task automatic model_check();
    logic [DATA_W:0] e0;
    logic [DATA_W:0] e1;
    int              st;
    e0 = (exp_q0.size() != 0) ? exp_q0[0] : hold0;
    e1 = (exp_q1.size() != 0) ? exp_q1[0] : hold1;
    st = !m_in_pkt ? 0 : (m_dest ? 2 : 1);
    chk1("in_ready", in_ready, model_ready());
    chk1("out0_valid", out0_valid, exp_q0.size() != 0);
    chk8("out0_data", out0_data, e0[DATA_W-1:0]);
    chk1("out0_last", out0_last, e0[DATA_W]);
    chk1("out1_valid", out1_valid, exp_q1.size() != 0);
    chk8("out1_data", out1_data, e1[DATA_W-1:0]);
    chk1("out1_last", out1_last, e1[DATA_W]);
    chkn("cnt0", int'(cnt0), m_cnt0);
    chkn("cnt1", int'(cnt1), m_cnt1);
    chkn("state", int'(dbg_state), st);
  endtask

  task automatic model_update();
    logic rdy;
    logic d;
    if (!rst_n) begin
      model_reset();
    end else begin
      rdy = model_ready();
      d   = model_dest();
      if (exp_q0.size() != 0 && out0_ready) begin
        void'(exp_q0.pop_front());
        m_cnt0 = (m_cnt0 + 1) % CNT_MOD;
      end
      if (exp_q1.size() != 0 && out1_ready) begin
        void'(exp_q1.pop_front());
        m_cnt1 = (m_cnt1 + 1) % CNT_MOD;
      end
      if (in_valid && rdy) begin
        if (d) begin
          exp_q1.push_back({in_last, in_data});
          hold1 = {in_last, in_data};
        end else begin
          exp_q0.push_back({in_last, in_data});
          hold0 = {in_last, in_data};
        end
        if (!m_in_pkt) begin
          if (!in_last) begin
            m_in_pkt = 1'b1;
            m_dest   = in_sel;
          end
        end else if (in_last) begin
          m_in_pkt = 1'b0;
        end
      end
    end
  endtask

  // driver tasks: inputs change at posedge+1, outputs are sampled at the falling edge
  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [7:0] d, input logic l);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
    in_last  = l;
  endtask

  // Asserts reset away from any edge, checks the asynchronous clear, then releases it.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk1("rst out0_valid", out0_valid, 1'b0);
    chk1("rst out1_valid", out1_valid, 1'b0);
    chk8("rst out0_data", out0_data, 8'h00);
    chk8("rst out1_data", out1_data, 8'h00);
    chk1("rst out0_last", out0_last, 1'b0);
    chk1("rst out1_last", out1_last, 1'b0);
    chkn("rst cnt0", int'(cnt0), 0);
    chkn("rst cnt1", int'(cnt1), 0);
    chk1("rst in_ready", in_ready, 1'b0);
    chkn("rst state", int'(dbg_state), 0);
    model_reset();
    sample();
    advance();
    rst_n = 1'b1;
    sample();
    chk1("release in_ready", in_ready, 1'b1);
    advance();
  endtask

  typedef struct {
    logic       v;
    logic       sel;
    logic [7:0] d;
    logic       l;
    logic       e_rdy;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_l0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic       e_l1;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int c0_before;
    int c1_before;
    bit hold_in;

    // single beat to out1, then a 3-beat packet locked to out0 despite in_sel changing
    tbl[0] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'hA5, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'hA5, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 8'hA5, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 8'hA5, 1'b1};

    rst_n      = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].l);
      sample();
      chk1("tbl in_ready", in_ready, tbl[i].e_rdy);
      chk1("tbl out0_valid", out0_valid, tbl[i].e_v0);
      chk8("tbl out0_data", out0_data, tbl[i].e_d0);
      chk1("tbl out0_last", out0_last, tbl[i].e_l0);
      chk1("tbl out1_valid", out1_valid, tbl[i].e_v1);
      chk8("tbl out1_data", out1_data, tbl[i].e_d1);
      chk1("tbl out1_last", out1_last, tbl[i].e_l1);
      advance();
    end
    sample();
    chkn("tbl cnt0", int'(cnt0), 3);
    chkn("tbl cnt1", int'(cnt1), 1);
    chkn("tbl state idle", int'(dbg_state), 0);
    advance();

    // backpressure on out0: second beat waits, then enters the same cycle the first pops
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h01, 1'b1);
    sample();
    chk1("bp first ready", in_ready, 1'b1);
    advance();
    drive(1'b1, 1'b0, 8'h02, 1'b1);
    for (int i = 0; i < 2; i++) begin
      sample();
      chk1("bp stalled ready", in_ready, 1'b0);
      chk8("bp held data", out0_data, 8'h01);
      advance();
    end
    out0_ready = 1'b1;
    sample();
    chk1("bp release ready", in_ready, 1'b1);
    chk8("bp pop data", out0_data, 8'h01);
    advance();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    sample();
    chk1("bp second valid", out0_valid, 1'b1);
    chk8("bp second data", out0_data, 8'h02);
    advance();

    // back-to-back single-beat packets, alternating destination
    c0_before = int'(cnt0);
    c1_before = int'(cnt1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'(i % 2), 8'($urandom_range(0, 255)), 1'b1);
      sample();
      chk1("b2b in_ready", in_ready, 1'b1);
      advance();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    sample();
    advance();
    sample();
    chkn("b2b cnt0 delta", (int'(cnt0) - c0_before + CNT_MOD) % CNT_MOD, 4);
    chkn("b2b cnt1 delta", (int'(cnt1) - c1_before + CNT_MOD) % CNT_MOD, 4);
    advance();

    // random traffic; the producer holds its beat while it is not accepted
    hold_in = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!hold_in) begin
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0));
      end
      out0_ready = 1'($urandom_range(0, 3) != 0);
      out1_ready = 1'($urandom_range(0, 3) != 0);
      sample();
      hold_in = in_valid && !model_ready();
      advance();
    end
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    do_reset();

    // reset in the middle of a 4-beat packet, then a fresh packet to out1
    drive(1'b1, 1'b0, 8'hA1, 1'b0);
    sample();
    advance();
    drive(1'b1, 1'b0, 8'hA2, 1'b0);
    sample();
    advance();
    do_reset();
    drive(1'b1, 1'b1, 8'h7E, 1'b1);
    sample();
    advance();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    sample();
    chk1("mid rst out1_valid", out1_valid, 1'b1);
    chk8("mid rst out1_data", out1_data, 8'h7E);
    chk1("mid rst out0_valid", out0_valid, 1'b0);
    advance();

    // 17 deliveries on out0 wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b1);
      sample();
      advance();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    sample();
    advance();
    sample();
    chkn("wrap cnt0", int'(cnt0), 1);
    chkn("wrap cnt1", int'(cnt1), 1);
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
